// File: rtl/lan_defs_pkg.sv
// ============================================================================
// Module : lan_defs_pkg
// Brief  : Register map, command codes, socket states and ID value shared by
//          the LAN bus responder and its sub-blocks.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package lan_defs_pkg;

   localparam logic [9:0] c_addr_shar0    = 10'h008;
   localparam logic [9:0] c_addr_shar1    = 10'h00A;
   localparam logic [9:0] c_addr_shar2    = 10'h00C;
   localparam logic [9:0] c_addr_subr0    = 10'h014;
   localparam logic [9:0] c_addr_subr1    = 10'h016;
   localparam logic [9:0] c_addr_sipr0    = 10'h018;
   localparam logic [9:0] c_addr_sipr1    = 10'h01A;
   localparam logic [9:0] c_addr_idr      = 10'h0FE;
   localparam logic [9:0] c_addr_s0_mr    = 10'h200;
   localparam logic [9:0] c_addr_s0_cr    = 10'h202;
   localparam logic [9:0] c_addr_s0_ssr   = 10'h208;
   localparam logic [9:0] c_addr_s0_portr = 10'h20A;
   localparam logic [9:0] c_addr_txwr_hi  = 10'h220;
   localparam logic [9:0] c_addr_txwr_lo  = 10'h222;
   localparam logic [9:0] c_addr_rxrs_hi  = 10'h228;
   localparam logic [9:0] c_addr_rxrs_lo  = 10'h22A;
   localparam logic [9:0] c_addr_tx_fifo  = 10'h22E;
   localparam logic [9:0] c_addr_rx_fifo  = 10'h230;

   localparam logic [15:0] c_idr_value = 16'h5300;

   localparam logic [7:0] c_cmd_open   = 8'h01;
   localparam logic [7:0] c_cmd_listen = 8'h02;
   localparam logic [7:0] c_cmd_close  = 8'h10;
   localparam logic [7:0] c_cmd_send   = 8'h20;
   localparam logic [7:0] c_cmd_recv   = 8'h40;

   typedef enum logic [7:0] {
      SOCK_CLOSED      = 8'h00,
      SOCK_INIT        = 8'h13,
      SOCK_LISTEN      = 8'h14,
      SOCK_ESTABLISHED = 8'h17,
      SOCK_CLOSE_WAIT  = 8'h1C
   } sock_state_t;

   typedef struct packed {
      logic       hit;
      logic [2:0] idx;
   } cfg_sel_t;

   // Network configuration words (SHAR/SUBR/SIPR) share one register file.
   function automatic cfg_sel_t cfg_decode(input logic [9:0] addr);
      cfg_sel_t s;
      s.hit = 1'b1;
      s.idx = 3'd0;
      case (addr)
         c_addr_shar0: s.idx = 3'd0;
         c_addr_shar1: s.idx = 3'd1;
         c_addr_shar2: s.idx = 3'd2;
         c_addr_subr0: s.idx = 3'd3;
         c_addr_subr1: s.idx = 3'd4;
         c_addr_sipr0: s.idx = 3'd5;
         c_addr_sipr1: s.idx = 3'd6;
         default:      s.hit = 1'b0;
      endcase
      return s;
   endfunction

endpackage

`default_nettype wire

// File: rtl/lan_word_fifo.sv
// ============================================================================
// Module : lan_word_fifo
// Brief  : Synchronous show-ahead word FIFO with flush and occupancy count.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module lan_word_fifo #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   i_flush,
   input  logic                   i_push,
   input  logic [WIDTH-1:0]       i_data,
   input  logic                   i_pop,
   output logic [WIDTH-1:0]       o_head,
   output logic                   o_full,
   output logic                   o_empty,
   output logic [$clog2(DEPTH):0] o_count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_count;
   logic             w_push;
   logic             w_pop;

   assign o_full  = (r_count == (AW+1)'(DEPTH));
   assign o_empty = (r_count == '0);
   assign o_count = r_count;
   assign o_head  = r_mem[r_rd_ptr];
   assign w_push  = i_push & ~o_full;
   assign w_pop   = i_pop & ~o_empty;

   always_ff @(posedge clk) begin
      if (w_push && !i_flush) begin
         r_mem[r_wr_ptr] <= i_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
      end
   end

endmodule

`default_nettype wire

// File: rtl/lan_bus_responder.sv
// ============================================================================
// Module : lan_bus_responder
// Brief  : Host-bus register slave emulating one socket of a LAN controller,
//          with RX/TX word FIFOs and a peer-side stream interface.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module lan_bus_responder
   import lan_defs_pkg::*;
#(
   parameter int FIFO_DEPTH  = 16,
   parameter int HOLD_CYCLES = 8
) (
   input  logic        Clk,
   input  logic        Rst,
   input  logic [9:0]  LanAddr,
   inout  wire  [15:0] LanData,
   input  logic        LanCs,
   input  logic        LanRd,
   input  logic        LanWr,
   output logic        LanIrq,
   input  logic        ConnectReq,
   input  logic        DisconnectReq,
   input  logic        RxPush,
   input  logic [15:0] RxWord,
   output logic        RxFull,
   output logic        TxValid,
   output logic [15:0] TxWord,
   output logic        TxLast,
   input  logic        TxReady
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam int HW = $clog2(HOLD_CYCLES + 2);

   logic r_cs_s1, r_cs_s2, r_rd_s1, r_rd_s2, r_wr_s1, r_wr_s2;
   logic r_wr_act_d, r_rd_act_d;
   logic w_wr_act, w_rd_act, w_wr_start, w_rd_start;

   logic [15:0]  r_cfg [7];
   logic [15:0]  r_mr, r_portr;
   logic [31:0]  r_wrsr;
   logic [7:0]   r_cr;
   sock_state_t  r_state, w_state_nxt;
   logic         r_send_active;
   logic [CW-1:0] r_send_left;
   logic [15:0]  r_rd_data, w_rd_mux;
   logic         r_drive, w_lan_oe;
   logic [HW-1:0] r_hold;
   logic         r_irq;

   cfg_sel_t     w_cfg;
   logic         w_cmd_exec, w_send_start, w_flush, w_tx_beat;
   logic [32:0]  w_req_sum;
   logic [31:0]  w_req_words, w_rx_bytes;
   logic [CW-1:0] w_send_words;

   logic [15:0]  w_rx_head, w_tx_head;
   logic         w_rx_full, w_rx_empty, w_tx_full, w_tx_empty;
   logic [CW-1:0] w_rx_count, w_tx_count;
   logic         w_rx_push, w_rx_pop, w_tx_push;

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         {r_cs_s1, r_cs_s2, r_rd_s1, r_rd_s2, r_wr_s1, r_wr_s2} <= '1;
         r_wr_act_d <= 1'b0;
         r_rd_act_d <= 1'b0;
      end else begin
         {r_cs_s2, r_cs_s1} <= {r_cs_s1, LanCs};
         {r_rd_s2, r_rd_s1} <= {r_rd_s1, LanRd};
         {r_wr_s2, r_wr_s1} <= {r_wr_s1, LanWr};
         r_wr_act_d <= w_wr_act;
         r_rd_act_d <= w_rd_act;
      end
   end

   assign w_wr_act   = ~r_cs_s2 & ~r_wr_s2;
   assign w_rd_act   = ~r_cs_s2 & ~r_rd_s2;
   assign w_wr_start = w_wr_act & ~r_wr_act_d;
   assign w_rd_start = w_rd_act & ~r_rd_act_d;
   assign w_cfg      = cfg_decode(LanAddr);

   assign w_rx_push  = RxPush & (r_state == SOCK_ESTABLISHED) & ~w_rx_full;
   assign w_rx_pop   = w_rd_start & (LanAddr == c_addr_rx_fifo);
   assign w_tx_push  = w_wr_start & (LanAddr == c_addr_tx_fifo) & ~w_tx_full;
   assign w_tx_beat  = TxValid & TxReady;

   lan_word_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(16)) u_rx_fifo (
      .clk(Clk), .rst(Rst), .i_flush(w_flush),
      .i_push(w_rx_push), .i_data(RxWord), .i_pop(w_rx_pop),
      .o_head(w_rx_head), .o_full(w_rx_full), .o_empty(w_rx_empty), .o_count(w_rx_count)
   );

   lan_word_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(16)) u_tx_fifo (
      .clk(Clk), .rst(Rst), .i_flush(w_flush),
      .i_push(w_tx_push), .i_data(LanData), .i_pop(w_tx_beat),
      .o_head(w_tx_head), .o_full(w_tx_full), .o_empty(w_tx_empty), .o_count(w_tx_count)
   );

   // A pending command executes the cycle after it is written; SEND holds CR until done.
   assign w_cmd_exec   = (r_cr != 8'h00) & ~r_send_active;
   assign w_req_sum    = {1'b0, r_wrsr} + 33'd1;
   assign w_req_words  = w_req_sum[32:1];
   assign w_send_words = (w_req_words > 32'(w_tx_count)) ? w_tx_count : w_req_words[CW-1:0];
   assign w_send_start = w_cmd_exec & (r_cr == c_cmd_send) &
                         (r_state == SOCK_ESTABLISHED) & (w_send_words != '0);

   always_comb begin
      w_state_nxt = r_state;
      w_flush     = 1'b0;
      if (w_cmd_exec) begin
         case (r_cr)
            c_cmd_open:   if (r_state == SOCK_CLOSED && r_mr[3:0] == 4'h1) w_state_nxt = SOCK_INIT;
            c_cmd_listen: if (r_state == SOCK_INIT) w_state_nxt = SOCK_LISTEN;
            c_cmd_close: begin
               w_state_nxt = SOCK_CLOSED;
               w_flush     = 1'b1;
            end
            default: ;
         endcase
      end
      if (w_state_nxt == r_state) begin
         if (ConnectReq && r_state == SOCK_LISTEN)
            w_state_nxt = SOCK_ESTABLISHED;
         else if (DisconnectReq && r_state == SOCK_ESTABLISHED)
            w_state_nxt = SOCK_CLOSE_WAIT;
      end
   end

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) r_state <= SOCK_CLOSED;
      else     r_state <= w_state_nxt;
   end

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         for (int i = 0; i < 7; i++) r_cfg[i] <= '0;
         r_mr          <= '0;
         r_portr       <= '0;
         r_wrsr        <= '0;
         r_cr          <= '0;
         r_send_active <= 1'b0;
         r_send_left   <= '0;
         r_irq         <= 1'b1;
      end else begin
         r_irq <= ~((r_state == SOCK_ESTABLISHED) & ~w_rx_empty);
         if (w_cmd_exec && !w_send_start) r_cr <= '0;
         if (w_send_start) begin
            r_send_active <= 1'b1;
            r_send_left   <= w_send_words;
         end
         if (w_tx_beat) begin
            r_send_left <= r_send_left - CW'(1);
            if (r_send_left == CW'(1)) begin
               r_send_active <= 1'b0;
               r_cr          <= '0;
            end
         end
         if (w_wr_start) begin
            case (LanAddr)
               c_addr_s0_mr:    r_mr           <= LanData;
               c_addr_s0_portr: r_portr        <= LanData;
               c_addr_txwr_hi:  r_wrsr[31:16]  <= LanData;
               c_addr_txwr_lo:  r_wrsr[15:0]   <= LanData;
               c_addr_s0_cr:    if (!r_send_active) r_cr <= LanData[7:0];
               default:         if (w_cfg.hit) r_cfg[w_cfg.idx] <= LanData;
            endcase
         end
      end
   end

   assign w_rx_bytes = 32'({w_rx_count, 1'b0});

   always_comb begin
      w_rd_mux = '0;
      case (LanAddr)
         c_addr_idr:      w_rd_mux = c_idr_value;
         c_addr_s0_mr:    w_rd_mux = r_mr;
         c_addr_s0_cr:    w_rd_mux = {8'h00, r_cr};
         c_addr_s0_ssr:   w_rd_mux = {8'h00, r_state};
         c_addr_s0_portr: w_rd_mux = r_portr;
         c_addr_txwr_hi:  w_rd_mux = r_wrsr[31:16];
         c_addr_txwr_lo:  w_rd_mux = r_wrsr[15:0];
         c_addr_rxrs_hi:  w_rd_mux = w_rx_bytes[31:16];
         c_addr_rxrs_lo:  w_rd_mux = w_rx_bytes[15:0];
         c_addr_rx_fifo:  w_rd_mux = w_rx_empty ? 16'h0000 : w_rx_head;
         default:         if (w_cfg.hit) w_rd_mux = r_cfg[w_cfg.idx];
      endcase
   end

   // Bus stays driven through the read and HOLD_CYCLES after it; a host write cuts it off.
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         r_rd_data <= '0;
         r_drive   <= 1'b0;
         r_hold    <= '0;
      end else begin
         if (w_rd_start) begin
            r_rd_data <= w_rd_mux;
            r_drive   <= 1'b1;
         end
         if (w_rd_act) begin
            r_hold <= HW'(HOLD_CYCLES);
         end else if (r_drive) begin
            if (r_hold == '0) r_drive <= 1'b0;
            else              r_hold  <= r_hold - HW'(1);
         end
         if (!r_wr_s2) r_drive <= 1'b0;
      end
   end

   assign w_lan_oe = r_drive & r_wr_s2;
   assign LanData  = w_lan_oe ? r_rd_data : 16'hzzzz;

   assign LanIrq  = r_irq;
   assign RxFull  = w_rx_full;
   assign TxValid = r_send_active & ~w_tx_empty;
   assign TxWord  = TxValid ? w_tx_head : 16'h0000;
   assign TxLast  = TxValid & (r_send_left == CW'(1));

endmodule

`default_nettype wire

// File: tb/tb_lan_bus_responder.sv
// ============================================================================
// Module : tb_lan_bus_responder
// Brief  : Directed, table-driven bench for lan_bus_responder.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_lan_bus_responder;

   localparam int FIFO_DEPTH  = 16;
   localparam int HOLD_CYCLES = 8;

   logic        Clk = 1'b0;
   logic        Rst;
   logic [9:0]  LanAddr;
   wire  [15:0] LanData;
   logic        LanCs, LanRd, LanWr;
   logic        LanIrq;
   logic        ConnectReq, DisconnectReq;
   logic        RxPush;
   logic [15:0] RxWord;
   logic        RxFull;
   logic        TxValid;
   logic [15:0] TxWord;
   logic        TxLast;
   logic        TxReady;

   logic [15:0] r_tb_data;
   logic        r_tb_drive;
   assign LanData = r_tb_drive ? r_tb_data : 16'hzzzz;

   lan_bus_responder #(.FIFO_DEPTH(FIFO_DEPTH), .HOLD_CYCLES(HOLD_CYCLES)) dut (
      .Clk(Clk), .Rst(Rst), .LanAddr(LanAddr), .LanData(LanData),
      .LanCs(LanCs), .LanRd(LanRd), .LanWr(LanWr), .LanIrq(LanIrq),
      .ConnectReq(ConnectReq), .DisconnectReq(DisconnectReq),
      .RxPush(RxPush), .RxWord(RxWord), .RxFull(RxFull),
      .TxValid(TxValid), .TxWord(TxWord), .TxLast(TxLast), .TxReady(TxReady)
   );

   always #5 Clk = ~Clk;

   int n_cmp = 0;
   int n_bad = 0;
   logic [15:0] got_w [8];
   logic        got_l [8];

   typedef struct {
      bit          wr;
      logic [9:0]  addr;
      logic [15:0] data;
      logic [15:0] exp;
   } vec_t;

   vec_t vecs[18];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic host_write(input logic [9:0] addr, input logic [15:0] data);
      @(negedge Clk);
      LanAddr = addr; r_tb_data = data; r_tb_drive = 1'b1;
      LanCs = 1'b0; LanWr = 1'b0;
      repeat (4) @(negedge Clk);
      LanCs = 1'b1; LanWr = 1'b1;
      @(negedge Clk);
      r_tb_drive = 1'b0;
      repeat (2) @(negedge Clk);
   endtask

   task automatic host_read(input logic [9:0] addr, output logic [15:0] data);
      @(negedge Clk);
      LanAddr = addr; LanCs = 1'b0; LanRd = 1'b0;
      repeat (5) @(negedge Clk);
      data = LanData;
      LanCs = 1'b1; LanRd = 1'b1;
      repeat (HOLD_CYCLES + 5) @(negedge Clk);
   endtask

   task automatic read_check(input string name, input logic [9:0] addr, input logic [15:0] exp);
      logic [15:0] d;
      host_read(addr, d);
      check(name, d, exp);
   endtask

   task automatic rx_push(input logic [15:0] w);
      @(negedge Clk);
      RxPush = 1'b1; RxWord = w;
      @(negedge Clk);
      RxPush = 1'b0;
   endtask

   task automatic pulse_connect();
      @(negedge Clk); ConnectReq = 1'b1;
      @(negedge Clk); ConnectReq = 1'b0;
   endtask

   task automatic run_send(input int budget, output int nb);
      nb = 0;
      for (int c = 0; c < budget; c++) begin
         @(negedge Clk);
         TxReady = ~TxReady;
         #1;
         if (TxValid && TxReady) begin
            if (nb < 8) begin
               got_w[nb] = TxWord;
               got_l[nb] = TxLast;
            end
            nb++;
         end
      end
      @(negedge Clk);
      TxReady = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int nb;
      logic [15:0] d;

      Rst = 1'b1; LanAddr = '0; LanCs = 1'b1; LanRd = 1'b1; LanWr = 1'b1;
      ConnectReq = 1'b0; DisconnectReq = 1'b0; RxPush = 1'b0; RxWord = '0;
      TxReady = 1'b0; r_tb_data = '0; r_tb_drive = 1'b0;
      repeat (3) @(negedge Clk);
      check("rst_irq", LanIrq, 1'b1);
      check("rst_txvalid", TxValid, 1'b0);
      check("rst_txlast", TxLast, 1'b0);
      check("rst_txword", TxWord, 16'h0000);
      check("rst_rxfull", RxFull, 1'b0);
      Rst = 1'b0;
      repeat (2) @(negedge Clk);

      vecs[0]  = '{1'b1, 10'h20A, 16'd80,   16'h0000};
      vecs[1]  = '{1'b0, 10'h20A, 16'h0000, 16'd80};
      vecs[2]  = '{1'b0, 10'h0FE, 16'h0000, 16'h5300};
      vecs[3]  = '{1'b0, 10'h3FE, 16'h0000, 16'h0000};
      vecs[4]  = '{1'b1, 10'h008, 16'h0102, 16'h0000};
      vecs[5]  = '{1'b0, 10'h008, 16'h0000, 16'h0102};
      vecs[6]  = '{1'b1, 10'h01A, 16'hC0A8, 16'h0000};
      vecs[7]  = '{1'b0, 10'h01A, 16'h0000, 16'hC0A8};
      vecs[8]  = '{1'b0, 10'h018, 16'h0000, 16'h0000};
      vecs[9]  = '{1'b1, 10'h100, 16'hFFFF, 16'h0000};
      vecs[10] = '{1'b0, 10'h100, 16'h0000, 16'h0000};
      vecs[11] = '{1'b0, 10'h208, 16'h0000, 16'h0000};
      vecs[12] = '{1'b0, 10'h202, 16'h0000, 16'h0000};
      vecs[13] = '{1'b1, 10'h220, 16'h1234, 16'h0000};
      vecs[14] = '{1'b0, 10'h220, 16'h0000, 16'h1234};
      vecs[15] = '{1'b0, 10'h222, 16'h0000, 16'h0000};
      vecs[16] = '{1'b0, 10'h228, 16'h0000, 16'h0000};
      vecs[17] = '{1'b0, 10'h22A, 16'h0000, 16'h0000};

      for (int i = 0; i < 18; i++) begin
         if (vecs[i].wr) begin
            host_write(vecs[i].addr, vecs[i].data);
         end else begin
            host_read(vecs[i].addr, d);
            check($sformatf("vec%0d_rd_%h", i, vecs[i].addr), d, vecs[i].exp);
         end
      end

      // Socket bring-up
      host_write(10'h200, 16'h0001);
      host_write(10'h202, 16'h0001);
      read_check("ssr_init", 10'h208, 16'h0013);
      read_check("cr_cleared", 10'h202, 16'h0000);
      host_write(10'h202, 16'h0002);
      read_check("ssr_listen", 10'h208, 16'h0014);
      pulse_connect();
      read_check("ssr_estab", 10'h208, 16'h0017);
      check("irq_idle_estab", LanIrq, 1'b1);

      // RX path
      rx_push(16'h4451);
      rx_push(16'h3F00);
      repeat (2) @(negedge Clk);
      check("irq_rx_pending", LanIrq, 1'b0);
      read_check("rxrsr_hi", 10'h228, 16'h0000);
      read_check("rxrsr_lo", 10'h22A, 16'h0004);
      read_check("rx_pop0", 10'h230, 16'h4451);
      read_check("rx_pop1", 10'h230, 16'h3F00);
      read_check("rx_empty", 10'h230, 16'h0000);
      check("irq_rx_drained", LanIrq, 1'b1);

      // TX path: ceil(5/2)=3 words
      host_write(10'h22E, 16'hAAAA);
      host_write(10'h22E, 16'hBBBB);
      host_write(10'h22E, 16'hCCCC);
      host_write(10'h220, 16'h0000);
      host_write(10'h222, 16'h0005);
      host_write(10'h202, 16'h0020);
      run_send(20, nb);
      check("send3_beats", nb, 3);
      check("send3_w0", got_w[0], 16'hAAAA);
      check("send3_w1", got_w[1], 16'hBBBB);
      check("send3_w2", got_w[2], 16'hCCCC);
      check("send3_lasts", {got_l[0], got_l[1], got_l[2]}, 3'b001);
      check("send3_txvalid_after", TxValid, 1'b0);
      read_check("send3_cr", 10'h202, 16'h0000);

      // TX_WRSR=2 with two queued words sends only one
      host_write(10'h22E, 16'hDDDD);
      host_write(10'h22E, 16'hEEEE);
      host_write(10'h222, 16'h0002);
      host_write(10'h202, 16'h0020);
      run_send(20, nb);
      check("send1_beats", nb, 1);
      check("send1_w0", got_w[0], 16'hDDDD);
      check("send1_last", got_l[0], 1'b1);

      // TX_WRSR=0: no beat
      host_write(10'h222, 16'h0000);
      host_write(10'h202, 16'h0020);
      run_send(12, nb);
      check("send0_beats", nb, 0);
      read_check("send0_cr", 10'h202, 16'h0000);

      // RX overflow
      for (int i = 0; i <= FIFO_DEPTH; i++) rx_push(16'h1000 + 16'(i));
      @(negedge Clk);
      check("rx_full", RxFull, 1'b1);
      read_check("rx_full_rsr_lo", 10'h22A, 16'(2 * FIFO_DEPTH));
      read_check("rx_full_rsr_hi", 10'h228, 16'h0000);
      read_check("rx_full_head", 10'h230, 16'h1000);
      @(negedge Clk); DisconnectReq = 1'b1;
      @(negedge Clk); DisconnectReq = 1'b0;
      read_check("ssr_close_wait", 10'h208, 16'h001C);
      check("irq_close_wait", LanIrq, 1'b1);
      host_write(10'h202, 16'h0010);
      read_check("ssr_closed", 10'h208, 16'h0000);
      read_check("close_rsr_lo", 10'h22A, 16'h0000);
      check("close_rxfull", RxFull, 1'b0);

      // Reset in the middle of a read
      host_write(10'h202, 16'h0001);
      host_write(10'h202, 16'h0002);
      pulse_connect();
      rx_push(16'h5A5A);
      repeat (2) @(negedge Clk);
      check("pre_rst_irq", LanIrq, 1'b0);
      @(negedge Clk);
      LanAddr = 10'h230; LanCs = 1'b0; LanRd = 1'b0;
      repeat (4) @(negedge Clk);
      check("pre_rst_oe", dut.w_lan_oe, 1'b1);
      check("pre_rst_data", LanData, 16'h5A5A);
      #2 Rst = 1'b1;
      #1;
      check("rst_mid_oe", dut.w_lan_oe, 1'b0);
      check("rst_mid_irq", LanIrq, 1'b1);
      check("rst_mid_txvalid", TxValid, 1'b0);
      check("rst_mid_txlast", TxLast, 1'b0);
      check("rst_mid_txword", TxWord, 16'h0000);
      check("rst_mid_rxfull", RxFull, 1'b0);
      LanCs = 1'b1; LanRd = 1'b1;
      @(negedge Clk);
      Rst = 1'b0;
      repeat (2) @(negedge Clk);
      read_check("post_rst_ssr", 10'h208, 16'h0000);
      read_check("post_rst_rsr", 10'h22A, 16'h0000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

`default_nettype wire
